elastic_pe_param: RTL and testbench
===================================

Name: elastic_pe_param

Overview:
- Parametrised elastic processing element for the elastic CGRA array. It uses valid/stop (SELF) handshakes on every neighbour link.
- Per context, it selects two operands from neighbour ports, local result registers, or a constant. It applies a built-in ALU op, buffers the result, and multicasts it to a masked subset of neighbours.
- New versus the previous PE:
  - generic port, register, context and buffer counts;
  - a constant operand source;
  - per-context repeat count;
  - finite execution with a drain phase and a done flag.

Parameters:
- DATA_WIDTH, 32, datapath width.
- NUM_PORTS, 4, neighbour links (in and out).
- REG_DEPTH, 2, local result registers, written round-robin.
- CONTEXT_DEPTH, 16, config memory entries; CW = clog2(CONTEXT_DEPTH).
- BUF_DEPTH, 2, result FIFO depth (>=1).
- SW, clog2(NUM_PORTS+REG_DEPTH+1), operand select width.
  - Source codes: 0..NUM_PORTS-1 are ports.
  - NUM_PORTS..NUM_PORTS+REG_DEPTH-1 are registers.
  - NUM_PORTS+REG_DEPTH is the constant.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  CW  context entry to write.
- cfg_src_a, cfg_src_b  in  SW  operand sources.
- cfg_op  in  4  ALU op.
- cfg_const  in  DATA_WIDTH  constant operand.
- cfg_out_mask  in  NUM_PORTS  destination ports.
- cfg_repeat  in  8  extra firings of this context (0 = fire once).
- start  in  1  begin execution.
- ctx_max  in  CW  last context id.
- loop_count  in  16  full context sweeps to run (0 = unbounded).
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- in_data  in  NUM_PORTS*DATA_WIDTH  neighbour inputs, port p at bits [p*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  NUM_PORTS.
- in_stop  out  NUM_PORTS.
- out_data  out  DATA_WIDTH  FIFO head, shared by all ports.
- out_valid  out  NUM_PORTS.
- out_stop  in  NUM_PORTS.

Behaviour:
- Clocking and reset: one clock `clk`; reset is synchronous and active-high.
- Reset (synchronous, checked at the clk edge):
  - State goes to IDLE.
  - Config memory, registers, FIFO, pointers and counters are cleared.
  - busy=0, done=0, out_valid=0, out_data=0, in_stop=all 1.
  - Reset mid-RUN discards FIFO contents with no further outputs.
- Transfer rule: on a link, data moves in a cycle where valid=1 and stop=0.
- FSM states and transitions:
  - IDLE→RUN on start.
  - RUN→DRAIN when the final firing of sweep loop_count completes (loop_count≠0).
  - DRAIN→DONE when the FIFO is empty and no output is pending.
  - DONE→RUN on start.
  - start is ignored in RUN and DRAIN.
  - On entering RUN: ctx=0, rep_cnt=0, sweep_cnt=0. Registers and the round-robin pointer are kept.
- Config writes: cfg_we is honoured only in IDLE and DONE and ignored otherwise. A written entry is readable the next cycle.
- Operand validity:
  - A port source is valid when in_valid[src] is high.
  - Register and constant sources are always valid.
- Fire condition: state==RUN, A valid, B valid, and FIFO count<BUF_DEPTH. There is no full-bypass, even if a pop occurs in the same cycle.
- Input handshake:
  - in_stop[p] = !(fire && (src_a==p || src_b==p)).
  - Unselected ports stay stopped.
  - src_a==src_b==p consumes port p once; both operands take the same value.
- On fire:
  - The result and the context's out_mask are pushed into the FIFO.
  - The result is written to reg[wr_ptr]; wr_ptr wraps at REG_DEPTH-1. A register read in the next cycle sees the new value.
  - If rep_cnt==cfg_repeat[ctx]: rep_cnt=0 and ctx advances, wrapping ctx_max→0. The wrap increments sweep_cnt.
  - Otherwise rep_cnt++.
- ALU (result truncated to DATA_WIDTH):
  - 0 ADD, 1 SUB (a-b), 2 MUL (low half), 3 AND, 4 OR, 5 XOR.
  - 6 SHL a by b[clog2(DATA_WIDTH)-1:0], 7 SHR (logical, same shift amount).
  - 8 PASS a, 9 SLT (signed a<b → 1, else 0).
  - 10-15 produce 0.
- Latency: a result fired in cycle t appears on out_data/out_valid in cycle t+1 at the earliest.
- Output multicast:
  - out_valid[p] = head_valid & mask[p] & !sent[p].
  - sent[p] is set on transfer.
  - The head pops, and sent clears, in the cycle the last pending masked port transfers; simultaneous acceptances count.
  - A mask=0 entry pops one cycle after reaching the head, with no out_valid.
  - out_data is held stable while the head is pending.
- FIFO full: in_stop stays all 1 and ctx and rep_cnt hold.
- DRAIN: no firing; in_stop all 1; the output side continues until empty.
- loop_count=0: stays in RUN indefinitely; sweep_cnt wraps silently.

Test Plan:
1. Configure ctx0: src_a=port0, src_b=const, const=5, op ADD, mask=0b0101, ctx_max=0, loop_count=3. Then start, and drive port0 with valid data 10, 20, 30. Required response:
   - out_valid[0] and out_valid[2] carry 15, 25, 35, the first appearing 1 cycle after fire.
   - done rises after the third pop.
   - busy=0 in DONE.
2. Hold out_stop[2]=1 for 4 cycles with BUF_DEPTH=2. Required response:
   - Port 0 accepts once and does not re-present.
   - The FIFO fills after 2 fires; in_stop[0] stays 1.
   - Releasing the stop pops entries in order with no loss or duplication.
3. Configure src_a=src_b=port1 with op MUL and input 7. Required response:
   - One transfer on port1 (in_stop[1]=0 for exactly one cycle).
   - Output 49.
4. Two contexts, ctx0 ADD with repeat=2 and ctx1 SUB, ctx_max=1, loop_count=2. Required response:
   - Fire sequence of ops: ADD, ADD, ADD, SUB, ADD, ADD, ADD, SUB.
   - Then DRAIN→DONE.
5. Accumulator: src_a=reg0, src_b=port0, op ADD, REG_DEPTH=1, inputs 1, 2, 3. Required response: outputs 1, 3, 6.
6. Edge cases:
   - Assert reset during RUN with 2 FIFO entries: the next cycle has out_valid=0, in_stop all 1, busy=0.
   - cfg_we during RUN leaves the memory unchanged.
   - mask=0 context: no output, and the FIFO drains.

Source files
------------

// File: rtl/elastic_pe_param.sv
// Purpose : elastic CGRA processing element with a context-sequenced ALU, a local
//           result register file, a constant operand, and a multicast result FIFO.
// Latency : a result fired in cycle t is visible on out_data/out_valid in cycle t+1.
// Backpressure: a full result FIFO stops all inputs (in_stop=1); out_stop holds the
//           head until every masked destination has accepted it.
// Ports   : clk/reset (sync, active-high); cfg_* writes one context entry (IDLE/DONE only);
//           start/ctx_max/loop_count control execution, busy/done report it;
//           in_data/in_valid/in_stop are the neighbour inputs; out_data/out_valid/out_stop
//           are the multicast outputs (one shared data bus, per-port valid).
module elastic_pe_param #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_PORTS     = 4,
    parameter int REG_DEPTH     = 2,
    parameter int CONTEXT_DEPTH = 16,
    parameter int BUF_DEPTH     = 2,
    localparam int CW = (CONTEXT_DEPTH > 1) ? $clog2(CONTEXT_DEPTH) : 1,
    localparam int SW = $clog2(NUM_PORTS + REG_DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_we,
    input  logic [CW-1:0]                   cfg_addr,
    input  logic [SW-1:0]                   cfg_src_a,
    input  logic [SW-1:0]                   cfg_src_b,
    input  logic [3:0]                      cfg_op,
    input  logic [DATA_WIDTH-1:0]           cfg_const,
    input  logic [NUM_PORTS-1:0]            cfg_out_mask,
    input  logic [7:0]                      cfg_repeat,
    input  logic                            start,
    input  logic [CW-1:0]                   ctx_max,
    input  logic [15:0]                     loop_count,
    output logic                            busy,
    output logic                            done,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_stop,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [NUM_PORTS-1:0]            out_valid,
    input  logic [NUM_PORTS-1:0]            out_stop
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int RPW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam int BPW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int BCW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Context memory
    logic [SW-1:0]         mem_src_a_q [CONTEXT_DEPTH];
    logic [SW-1:0]         mem_src_b_q [CONTEXT_DEPTH];
    logic [3:0]            mem_op_q    [CONTEXT_DEPTH];
    logic [DATA_WIDTH-1:0] mem_const_q [CONTEXT_DEPTH];
    logic [NUM_PORTS-1:0]  mem_mask_q  [CONTEXT_DEPTH];
    logic [7:0]            mem_rep_q   [CONTEXT_DEPTH];

    // Sequencing
    logic [CW-1:0] ctx_q;
    logic [7:0]    rep_cnt_q;
    logic [15:0]   sweep_cnt_q;

    // Local result registers
    logic [DATA_WIDTH-1:0] regs_q [REG_DEPTH];
    logic [RPW-1:0]        reg_wr_ptr_q;

    // Result FIFO
    logic [DATA_WIDTH-1:0] fifo_dat_q  [BUF_DEPTH];
    logic [NUM_PORTS-1:0]  fifo_mask_q [BUF_DEPTH];
    logic [BPW-1:0]        fifo_wr_ptr_q, fifo_rd_ptr_q;
    logic [BCW-1:0]        fifo_cnt_q;
    logic [NUM_PORTS-1:0]  sent_q, sent_d;

    // Current context fields
    logic [SW-1:0]         cur_src_a, cur_src_b;
    logic [3:0]            cur_op;
    logic [DATA_WIDTH-1:0] cur_const;
    logic [NUM_PORTS-1:0]  cur_mask;
    logic [7:0]            cur_rep;

    assign cur_src_a = mem_src_a_q[ctx_q];
    assign cur_src_b = mem_src_b_q[ctx_q];
    assign cur_op    = mem_op_q[ctx_q];
    assign cur_const = mem_const_q[ctx_q];
    assign cur_mask  = mem_mask_q[ctx_q];
    assign cur_rep   = mem_rep_q[ctx_q];

    // Operand selection: anything not a port or register code reads the constant.
    logic [DATA_WIDTH-1:0] op_a, op_b;
    logic                  a_vld, b_vld;

    always_comb begin
        op_a  = cur_const;
        op_b  = cur_const;
        a_vld = 1'b1;
        b_vld = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (cur_src_a == SW'(p)) begin
                op_a  = in_data[p*DATA_WIDTH +: DATA_WIDTH];
                a_vld = in_valid[p];
            end
            if (cur_src_b == SW'(p)) begin
                op_b  = in_data[p*DATA_WIDTH +: DATA_WIDTH];
                b_vld = in_valid[p];
            end
        end
        for (int r = 0; r < REG_DEPTH; r++) begin
            if (cur_src_a == SW'(NUM_PORTS + r)) op_a = regs_q[r];
            if (cur_src_b == SW'(NUM_PORTS + r)) op_b = regs_q[r];
        end
    end

    // ALU
    logic [DATA_WIDTH-1:0] alu_res;

    always_comb begin
        alu_res = '0;
        case (cur_op)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a * op_b;
            4'd3:    alu_res = op_a & op_b;
            4'd4:    alu_res = op_a | op_b;
            4'd5:    alu_res = op_a ^ op_b;
            4'd6:    alu_res = op_a << op_b[SHW-1:0];
            4'd7:    alu_res = op_a >> op_b[SHW-1:0];
            4'd8:    alu_res = op_a;
            4'd9:    alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_res = '0;
        endcase
    end

    // Firing: no full-bypass, so a pop in the same cycle does not free a slot.
    logic fifo_full, fire, ctx_last, ctx_wrap, final_fire;

    assign fifo_full  = (fifo_cnt_q == BCW'(BUF_DEPTH));
    assign fire       = (state_q == ST_RUN) && a_vld && b_vld && !fifo_full;
    assign ctx_last   = (rep_cnt_q == cur_rep);
    assign ctx_wrap   = ctx_last && (ctx_q == ctx_max);
    assign final_fire = ctx_wrap && (loop_count != 16'd0) && ((sweep_cnt_q + 16'd1) == loop_count);

    // A port selected by both operands is still consumed only once.
    always_comb begin
        in_stop = '1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (fire && ((cur_src_a == SW'(p)) || (cur_src_b == SW'(p)))) in_stop[p] = 1'b0;
        end
    end

    // Multicast output: head pops once every masked port has taken it,
    // counting ports that accept in this very cycle.
    logic                 head_vld, pop;
    logic [NUM_PORTS-1:0] head_mask, xfer;

    assign head_vld  = (fifo_cnt_q != '0);
    assign head_mask = fifo_mask_q[fifo_rd_ptr_q];
    assign out_valid = head_vld ? (head_mask & ~sent_q) : '0;
    assign out_data  = head_vld ? fifo_dat_q[fifo_rd_ptr_q] : '0;
    assign xfer      = out_valid & ~out_stop;
    assign pop       = head_vld && ((head_mask & ~(sent_q | xfer)) == '0);
    assign sent_d    = pop ? '0 : (sent_q | xfer);

    assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);

    logic enter_run, cfg_wr_en;
    assign enter_run = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
    assign cfg_wr_en = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && cfg_we;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (fire && final_fire) state_d = ST_DRAIN;
            ST_DRAIN: if (!head_vld) state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ctx_q         <= '0;
            rep_cnt_q     <= '0;
            sweep_cnt_q   <= '0;
            reg_wr_ptr_q  <= '0;
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_cnt_q    <= '0;
            sent_q        <= '0;
            for (int c = 0; c < CONTEXT_DEPTH; c++) begin
                mem_src_a_q[c] <= '0;
                mem_src_b_q[c] <= '0;
                mem_op_q[c]    <= '0;
                mem_const_q[c] <= '0;
                mem_mask_q[c]  <= '0;
                mem_rep_q[c]   <= '0;
            end
            for (int r = 0; r < REG_DEPTH; r++) regs_q[r] <= '0;
            for (int b = 0; b < BUF_DEPTH; b++) begin
                fifo_dat_q[b]  <= '0;
                fifo_mask_q[b] <= '0;
            end
        end else begin
            state_q <= state_d;
            sent_q  <= sent_d;

            if (cfg_wr_en) begin
                mem_src_a_q[cfg_addr] <= cfg_src_a;
                mem_src_b_q[cfg_addr] <= cfg_src_b;
                mem_op_q[cfg_addr]    <= cfg_op;
                mem_const_q[cfg_addr] <= cfg_const;
                mem_mask_q[cfg_addr]  <= cfg_out_mask;
                mem_rep_q[cfg_addr]   <= cfg_repeat;
            end

            if (enter_run) begin
                ctx_q       <= '0;
                rep_cnt_q   <= '0;
                sweep_cnt_q <= '0;
            end else if (fire) begin
                if (ctx_last) begin
                    rep_cnt_q <= '0;
                    ctx_q     <= (ctx_q == ctx_max) ? '0 : ctx_q + CW'(1);
                    if (ctx_wrap) sweep_cnt_q <= sweep_cnt_q + 16'd1;
                end else begin
                    rep_cnt_q <= rep_cnt_q + 8'd1;
                end
            end

            if (fire) begin
                for (int r = 0; r < REG_DEPTH; r++) begin
                    if (reg_wr_ptr_q == RPW'(r)) regs_q[r] <= alu_res;
                end
                reg_wr_ptr_q <= (reg_wr_ptr_q == RPW'(REG_DEPTH - 1)) ? '0 : reg_wr_ptr_q + RPW'(1);
                for (int b = 0; b < BUF_DEPTH; b++) begin
                    if (fifo_wr_ptr_q == BPW'(b)) begin
                        fifo_dat_q[b]  <= alu_res;
                        fifo_mask_q[b] <= cur_mask;
                    end
                end
                fifo_wr_ptr_q <= (fifo_wr_ptr_q == BPW'(BUF_DEPTH - 1)) ? '0 : fifo_wr_ptr_q + BPW'(1);
            end

            if (pop) begin
                fifo_rd_ptr_q <= (fifo_rd_ptr_q == BPW'(BUF_DEPTH - 1)) ? '0 : fifo_rd_ptr_q + BPW'(1);
            end

            case ({fire, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + BCW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - BCW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_elastic_pe_param.sv
// Directed bench for elastic_pe_param (REG_DEPTH=1 so register source 4 is an accumulator).
// Source codes: ports 0..3, reg0 = 4, constant = 5.
module tb_elastic_pe_param;

    localparam int DW = 32;
    localparam int NP = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            cfg_we;
    logic [3:0]      cfg_addr;
    logic [2:0]      cfg_src_a, cfg_src_b;
    logic [3:0]      cfg_op;
    logic [DW-1:0]   cfg_const;
    logic [NP-1:0]   cfg_out_mask;
    logic [7:0]      cfg_repeat;
    logic            start;
    logic [3:0]      ctx_max;
    logic [15:0]     loop_count;
    logic            busy, done;
    logic [NP*DW-1:0] in_data;
    logic [NP-1:0]   in_valid, in_stop;
    logic [DW-1:0]   out_data;
    logic [NP-1:0]   out_valid, out_stop;

    always #5 clk = ~clk;

    elastic_pe_param #(
        .DATA_WIDTH(DW), .NUM_PORTS(NP), .REG_DEPTH(1), .CONTEXT_DEPTH(16), .BUF_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_src_a(cfg_src_a), .cfg_src_b(cfg_src_b), .cfg_op(cfg_op),
        .cfg_const(cfg_const), .cfg_out_mask(cfg_out_mask), .cfg_repeat(cfg_repeat),
        .start(start), .ctx_max(ctx_max), .loop_count(loop_count),
        .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_stop(in_stop),
        .out_data(out_data), .out_valid(out_valid), .out_stop(out_stop)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] stim [0:15];
    logic [DW-1:0] got  [0:15];
    int stim_n, used_n, got_n;
    logic seen_done, ov_seen;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic cfg_ctx(input logic [3:0] addr, input logic [2:0] sa, input logic [2:0] sb,
                           input logic [3:0] op, input logic [DW-1:0] cst,
                           input logic [NP-1:0] mask, input logic [7:0] rep);
        cfg_addr = addr; cfg_src_a = sa; cfg_src_b = sb; cfg_op = op;
        cfg_const = cst; cfg_out_mask = mask; cfg_repeat = rep;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        seen_done = 1'b0;
        for (int c = 0; c < budget && !seen_done; c++) begin
            settle();
            if (done) seen_done = 1'b1;
            else tick();
        end
        check_val("done_reached", seen_done, 1);
        check_val("busy_in_done", busy, 0);
    endtask

    // Feeds stim[] into port ip and records every transfer on output port op_port until done.
    task automatic run_collect(input int ip, input int op_port, input int budget);
        got_n = 0; used_n = 0; seen_done = 1'b0; ov_seen = 1'b0;
        for (int c = 0; c < budget && !seen_done; c++) begin
            in_valid = '0;
            if (used_n < stim_n) begin
                in_valid[ip] = 1'b1;
                in_data[ip*DW +: DW] = stim[used_n];
            end
            settle();
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (out_valid != '0) ov_seen = 1'b1;
                if (out_valid[op_port] && !out_stop[op_port]) begin
                    if (got_n < 16) got[got_n] = out_data;
                    got_n++;
                end
                if (in_valid[ip] && !in_stop[ip]) used_n++;
                tick();
            end
        end
        in_valid = '0;
        check_val("collect_done_reached", seen_done, 1);
        check_val("collect_busy_in_done", busy, 0);
    endtask

    logic [DW-1:0] exp4 [0:7];

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_src_a = '0; cfg_src_b = '0;
        cfg_op = '0; cfg_const = '0; cfg_out_mask = '0; cfg_repeat = '0;
        start = 1'b0; ctx_max = '0; loop_count = '0;
        in_data = '0; in_valid = '0; out_stop = '0;
        tick(); tick();
        settle();
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_in_stop", in_stop, 4'hF);
        reset = 1'b0;
        tick();

        // 1: port0 + const 5, multicast to ports 0 and 2, three sweeps
        cfg_ctx(4'd0, 3'd0, 3'd5, 4'd0, 32'd5, 4'b0101, 8'd0);
        ctx_max = 4'd0; loop_count = 16'd3;
        start_pulse();
        in_valid = 4'b0001; in_data[31:0] = 32'd10;
        settle();
        check_val("t1_stop_fire1", in_stop, 4'b1110);
        check_val("t1_no_out_yet", out_valid, 4'b0000);
        check_val("t1_busy", busy, 1);
        tick();
        in_data[31:0] = 32'd20;
        settle();
        check_val("t1_ov1", out_valid, 4'b0101);
        check_val("t1_out1", out_data, 32'd15);
        check_val("t1_stop_fire2", in_stop, 4'b1110);
        tick();
        in_data[31:0] = 32'd30;
        settle();
        check_val("t1_out2", out_data, 32'd25);
        tick();
        in_valid = '0;
        settle();
        check_val("t1_out3", out_data, 32'd35);
        check_val("t1_ov3", out_valid, 4'b0101);
        check_val("t1_drain_stop", in_stop, 4'hF);
        check_val("t1_drain_busy", busy, 1);
        tick();
        wait_done(10);

        // 2: out_stop[2] held for four cycles, FIFO depth 2
        start_pulse();
        out_stop = 4'b0100;
        in_valid = 4'b0001; in_data[31:0] = 32'd100;
        settle();
        check_val("t2_fire_a", in_stop, 4'b1110);
        tick();
        in_data[31:0] = 32'd200;
        settle();
        check_val("t2_ov_b", out_valid, 4'b0101);
        check_val("t2_out_b", out_data, 32'd105);
        check_val("t2_fire_b", in_stop, 4'b1110);
        tick();
        in_data[31:0] = 32'd300;
        settle();
        check_val("t2_ov_c_no_represent", out_valid, 4'b0100);
        check_val("t2_full_stop_c", in_stop, 4'hF);
        tick();
        settle();
        check_val("t2_ov_d", out_valid, 4'b0100);
        check_val("t2_out_d_stable", out_data, 32'd105);
        check_val("t2_full_stop_d", in_stop, 4'hF);
        tick();
        out_stop = 4'b0000;
        settle();
        check_val("t2_ov_e", out_valid, 4'b0100);
        check_val("t2_no_bypass_e", in_stop, 4'hF);
        tick();
        settle();
        check_val("t2_out_f", out_data, 32'd205);
        check_val("t2_ov_f", out_valid, 4'b0101);
        check_val("t2_fire_f", in_stop, 4'b1110);
        tick();
        in_valid = '0;
        settle();
        check_val("t2_out_g", out_data, 32'd305);
        check_val("t2_ov_g", out_valid, 4'b0101);
        check_val("t2_stop_g", in_stop, 4'hF);
        tick();
        wait_done(10);

        // 3: same port on both operands, MUL
        cfg_ctx(4'd0, 3'd1, 3'd1, 4'd2, 32'd0, 4'b0001, 8'd0);
        loop_count = 16'd1;
        start_pulse();
        for (int i = 0; i < 5; i++) stim[i] = 32'd7;
        stim_n = 5;
        run_collect(1, 0, 20);
        check_val("t3_port1_transfers", used_n, 1);
        check_val("t3_out_count", got_n, 1);
        check_val("t3_out", got[0], 32'd49);

        // 4: ADD with repeat 2, then SUB, two sweeps
        cfg_ctx(4'd0, 3'd0, 3'd5, 4'd0, 32'd3, 4'b0001, 8'd2);
        cfg_ctx(4'd1, 3'd0, 3'd5, 4'd1, 32'd3, 4'b0001, 8'd0);
        ctx_max = 4'd1; loop_count = 16'd2;
        start_pulse();
        for (int i = 0; i < 12; i++) stim[i] = 32'd10;
        stim_n = 12;
        exp4[0] = 13; exp4[1] = 13; exp4[2] = 13; exp4[3] = 7;
        exp4[4] = 13; exp4[5] = 13; exp4[6] = 13; exp4[7] = 7;
        run_collect(0, 0, 60);
        check_val("t4_fires", used_n, 8);
        check_val("t4_out_count", got_n, 8);
        for (int i = 0; i < 8; i++) check_val($sformatf("t4_out%0d", i), got[i], exp4[i]);

        // 6a: reset during RUN with two FIFO entries
        cfg_ctx(4'd0, 3'd0, 3'd5, 4'd0, 32'd5, 4'b0001, 8'd0);
        ctx_max = 4'd0; loop_count = 16'd0;
        out_stop = 4'hF;
        start_pulse();
        in_valid = 4'b0001; in_data[31:0] = 32'd1;
        tick(); tick(); tick();
        settle();
        check_val("t6a_pending", out_valid, 4'b0001);
        check_val("t6a_full_stop", in_stop, 4'hF);
        check_val("t6a_busy_run", busy, 1);
        reset = 1'b1; in_valid = '0;
        tick();
        settle();
        check_val("t6a_rst_ov", out_valid, 4'b0000);
        check_val("t6a_rst_stop", in_stop, 4'hF);
        check_val("t6a_rst_busy", busy, 0);
        check_val("t6a_rst_data", out_data, 32'd0);
        reset = 1'b0; out_stop = 4'h0;
        tick();
        settle();
        check_val("t6a_post_ov", out_valid, 4'b0000);
        check_val("t6a_post_done", done, 0);

        // 5: accumulator through reg0 (registers cleared by the reset above)
        cfg_ctx(4'd0, 3'd4, 3'd0, 4'd0, 32'd0, 4'b0001, 8'd0);
        ctx_max = 4'd0; loop_count = 16'd3;
        start_pulse();
        stim[0] = 32'd1; stim[1] = 32'd2; stim[2] = 32'd3;
        stim_n = 3;
        run_collect(0, 0, 30);
        check_val("t5_out_count", got_n, 3);
        check_val("t5_out0", got[0], 32'd1);
        check_val("t5_out1", got[1], 32'd3);
        check_val("t5_out2", got[2], 32'd6);

        // 6b: cfg_we during RUN is ignored
        cfg_ctx(4'd0, 3'd0, 3'd5, 4'd0, 32'd5, 4'b0001, 8'd0);
        loop_count = 16'd1;
        start_pulse();
        cfg_ctx(4'd0, 3'd0, 3'd5, 4'd0, 32'd100, 4'b0001, 8'd0);
        stim[0] = 32'd1;
        stim_n = 1;
        run_collect(0, 0, 20);
        check_val("t6b_out_count", got_n, 1);
        check_val("t6b_cfg_unchanged", got[0], 32'd6);

        // 6c: mask=0 context produces nothing and still drains
        cfg_ctx(4'd0, 3'd5, 3'd5, 4'd0, 32'd1, 4'b0000, 8'd0);
        loop_count = 16'd2;
        start_pulse();
        stim_n = 0;
        run_collect(0, 0, 20);
        check_val("t6c_no_out_valid", ov_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
